// File: rtl/mul_seq_ctrl_if.sv
// Request/response/multiplier bundle for the multiply request sequencer.
//
// Handshake semantics (both Req and Resp ports): a transfer happens on a
// rising Clk edge where Valid and Ready are both 1. The producer keeps Valid
// and its payload stable until the transfer; the consumer may drive Ready
// freely. Req_Ready here additionally depends on the multiplier being idle.
interface mul_seq_ctrl_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [15:0] Req_A;
    logic [15:0] Req_B;
    logic        Req_Signed;
    logic        Resp_Valid;
    logic        Resp_Ready;
    logic [31:0] Resp_Produto;
    logic        Resp_Err;
    logic [15:0] Mul_Multiplicando;
    logic [15:0] Mul_Multiplicador;
    logic        Mul_St;
    logic        Mul_Done;
    logic        Mul_Idle;
    logic [31:0] Mul_Produto;

    // Sequencer side.
    modport slave (
        input  Req_Valid, Req_A, Req_B, Req_Signed, Resp_Ready,
               Mul_Done, Mul_Idle, Mul_Produto,
        output Req_Ready, Resp_Valid, Resp_Produto, Resp_Err,
               Mul_Multiplicando, Mul_Multiplicador, Mul_St
    );

    // Core + multiplier side (drives requests, consumes responses).
    modport master (
        output Req_Valid, Req_A, Req_B, Req_Signed, Resp_Ready,
               Mul_Done, Mul_Idle, Mul_Produto,
        input  Req_Ready, Resp_Valid, Resp_Produto, Resp_Err,
               Mul_Multiplicando, Mul_Multiplicador, Mul_St
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer in front of the 16x16 shift-add multiplier: takes one request,
// feeds operand magnitudes to the multiplier, restores the sign of the
// product and returns it, with a zero shortcut and a WAIT timeout.
module mul_seq_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic           Clk,
    input  logic           Rst,
    mul_seq_ctrl_if.slave  bus,
    output logic [1:0]     dbg_state_o
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q;
    logic [15:0]   opa_q;
    logic [15:0]   opb_q;
    logic          st_q;
    logic          resp_valid_q;
    logic [31:0]   resp_prod_q;
    logic          resp_err_q;

    logic [15:0]   mag_a;
    logic [15:0]   mag_b;
    logic          neg;
    logic          zero;
    logic          accept;
    logic [31:0]   prod_fix;

    // Operand magnitudes, sign and zero detection for the incoming request.
    always_comb begin
        mag_a    = (bus.Req_Signed && bus.Req_A[15]) ? 16'(~bus.Req_A + 16'd1) : bus.Req_A;
        mag_b    = (bus.Req_Signed && bus.Req_B[15]) ? 16'(~bus.Req_B + 16'd1) : bus.Req_B;
        neg      = bus.Req_Signed && (bus.Req_A[15] ^ bus.Req_B[15]);
        zero     = (bus.Req_A == 16'd0) || (bus.Req_B == 16'd0);
        accept   = bus.Req_Valid && bus.Req_Ready;
        prod_fix = neg_q ? 32'(~bus.Mul_Produto + 32'd1) : bus.Mul_Produto;
    end

    // Ready only while idle with an idle multiplier; never during reset.
    assign bus.Req_Ready         = (state_q == S_IDLE) && bus.Mul_Idle && !Rst;
    assign bus.Resp_Valid        = resp_valid_q;
    assign bus.Resp_Produto      = resp_prod_q;
    assign bus.Resp_Err          = resp_err_q;
    assign bus.Mul_Multiplicando = opa_q;
    assign bus.Mul_Multiplicador = opb_q;
    assign bus.Mul_St            = st_q;
    assign dbg_state_o           = state_q;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            opa_q        <= 16'd0;
            opb_q        <= 16'd0;
            st_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_prod_q  <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    st_q <= 1'b0;
                    if (accept) begin
                        neg_q <= neg;
                        if (zero) begin
                            // Zero operand: answer directly, multiplier untouched.
                            resp_prod_q  <= 32'd0;
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            opa_q   <= mag_a;
                            opb_q   <= mag_b;
                            st_q    <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    st_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.Mul_Done) begin
                        resp_prod_q  <= prod_fix;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        resp_prod_q  <= 32'd0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.Resp_Ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
